// File: rtl/tms9_group_feeder_pkg.sv
// Shared types for the TestMasterSlave9 group feeder: FSM sections and 32-bit signed limits.
// Also provides the signed-add overflow helper used by tms9_acc_add.
package tms9_group_feeder_types;

  typedef enum logic [1:0] {
    section_idle = 2'd0,
    section_read = 2'd1,
    section_emit = 2'd2
  } sections_t;

  localparam logic signed [31:0] INT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic add_overflow(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

endpackage

// File: rtl/tms9_group_feeder_acc_add.sv
// Combinational 32-bit signed accumulate step with overflow flag.
// TMS9_FEEDER_SAT_EN selects a clamped result on overflow; otherwise the sum wraps.
module tms9_acc_add
  import tms9_group_feeder_types::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] y,
  output logic               ovf
);

  logic signed [31:0] wrap_s;

  // Raw add, overflow detection and result selection.
  always_comb begin
    wrap_s = a + b;
    ovf    = add_overflow(a, b, wrap_s);
`ifdef TMS9_FEEDER_SAT_EN
    if (ovf) begin
      y = a[31] ? INT_MIN : INT_MAX;
    end else begin
      y = wrap_s;
    end
`else
    y = wrap_s;
`endif
  end

endmodule

// File: rtl/tms9_group_feeder.sv
// Sums GROUP_LEN samples from a blocking handshake and strobes each sum downstream.
// Optional macro TMS9_FEEDER_SAT_EN: saturating, group-sticky accumulation instead of wrap.
module tms9_group_feeder
  import tms9_group_feeder_types::*;
#(
  parameter int GROUP_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [31:0]      b_in,
  input  logic                    b_in_sync,
  output logic                    b_in_notify,
  output logic signed [31:0]      s_out,
  output logic                    s_out_sync,
  output logic [CNT_W-1:0]        grp_cnt
);

  localparam logic [7:0]       LAST_IDX = 8'(GROUP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  sections_t          state_r, state_s;
  logic signed [31:0] sum_r, sum_s;
  logic [7:0]         idx_r, idx_s;
  logic signed [31:0] s_out_r, s_out_s;
  logic               sync_r, sync_s;
  logic               notify_r, notify_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic signed [31:0] add_y_s;
  logic               add_ovf_s;
  logic signed [31:0] acc_s;
`ifdef TMS9_FEEDER_SAT_EN
  logic               sat_r, sat_s;
`endif

  tms9_acc_add u_acc_add (
    .a   (sum_r),
    .b   (b_in),
    .y   (add_y_s),
    .ovf (add_ovf_s)
  );

  // Accumulate step; once a group saturates it keeps the clamped value.
  always_comb begin
`ifdef TMS9_FEEDER_SAT_EN
    if (sat_r) begin
      acc_s = sum_r;
    end else begin
      acc_s = add_y_s;
    end
`else
    acc_s = add_y_s;
`endif
  end

  // Section state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= section_idle;
    end else begin
      state_r <= state_s;
    end
  end

  // Next section plus next values of the accumulator and all registered outputs.
  always_comb begin
    state_s = state_r;
    sum_s   = sum_r;
    idx_s   = idx_r;
    s_out_s = s_out_r;
    sync_s  = 1'b0;
    cnt_s   = cnt_r;
`ifdef TMS9_FEEDER_SAT_EN
    sat_s   = sat_r;
`endif
    case (state_r)
      section_idle: begin
        state_s = section_read;
      end
      section_read: begin
        if (b_in_sync) begin
          sum_s = acc_s;
          idx_s = idx_r + 8'd1;
`ifdef TMS9_FEEDER_SAT_EN
          sat_s = sat_r | add_ovf_s;
`endif
          // The group-completing transfer publishes the sum so the strobe lands in the emit cycle.
          if (idx_r == LAST_IDX) begin
            s_out_s = acc_s;
            sync_s  = 1'b1;
            cnt_s   = cnt_r + CNT_ONE;
            state_s = section_emit;
          end else begin
            state_s = section_read;
          end
        end else begin
          state_s = section_read;
        end
      end
      section_emit: begin
        sum_s   = 32'sd0;
        idx_s   = 8'd0;
`ifdef TMS9_FEEDER_SAT_EN
        sat_s   = 1'b0;
`endif
        state_s = section_read;
      end
      default: begin
        state_s = section_idle;
      end
    endcase
    notify_s = (state_s == section_read);
  end

  // Accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r    <= 32'sd0;
      idx_r    <= 8'd0;
      s_out_r  <= 32'sd0;
      sync_r   <= 1'b0;
      notify_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
`ifdef TMS9_FEEDER_SAT_EN
      sat_r    <= 1'b0;
`endif
    end else begin
      sum_r    <= sum_s;
      idx_r    <= idx_s;
      s_out_r  <= s_out_s;
      sync_r   <= sync_s;
      notify_r <= notify_s;
      cnt_r    <= cnt_s;
`ifdef TMS9_FEEDER_SAT_EN
      sat_r    <= sat_s;
`endif
    end
  end

  assign b_in_notify = notify_r;
  assign s_out       = s_out_r;
  assign s_out_sync  = sync_r;
  assign grp_cnt     = cnt_r;

endmodule
